// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and addressing helpers for the LCD text buffer.
package lcd_pkg;

  localparam int LINE_WIDTH   = 20;
  localparam int LINES        = 4;
  localparam int MAX_MEM      = LINE_WIDTH * LINES;
  localparam int MEM_BITS     = $clog2(MAX_MEM);
  localparam int HOLDOFF      = 250;
  localparam int BUSY_TIMEOUT = 16;
  localparam int HOLD_BITS    = $clog2(HOLDOFF);
  localparam int WAIT_BITS    = $clog2(BUSY_TIMEOUT);

  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_TILDE = 8'h7E;

  localparam logic [MEM_BITS-1:0]  ADDR_LAST = MEM_BITS'(MAX_MEM - 1);
  localparam logic [MEM_BITS-1:0]  ADDR_ONE  = MEM_BITS'(1'b1);
  localparam logic [MEM_BITS-1:0]  LW_ADDR   = MEM_BITS'(LINE_WIDTH);
  localparam logic [4:0]           COL_LAST  = 5'(LINE_WIDTH - 1);
  localparam logic [1:0]           ROW_LAST  = 2'(LINES - 1);
  localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(HOLDOFF - 1);
  localparam logic [HOLD_BITS-1:0] HOLD_ONE  = HOLD_BITS'(1'b1);
  localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(BUSY_TIMEOUT - 1);
  localparam logic [WAIT_BITS-1:0] WAIT_ONE  = WAIT_BITS'(1'b1);

  typedef enum logic [0:0] {
    MS_CLEAR = 1'b0,
    MS_IDLE  = 1'b1
  } main_state_e;

  typedef enum logic [2:0] {
    R_IDLE    = 3'd0,
    R_HOLD    = 3'd1,
    R_TRIG    = 3'd2,
    R_WAIT_HI = 3'd3,
    R_WAIT_LO = 3'd4
  } ref_state_e;

  function automatic logic [MEM_BITS-1:0] cell_addr(input logic [1:0] row, input logic [4:0] col);
    return (MEM_BITS'(row) * LW_ADDR) + MEM_BITS'(col);
  endfunction

  // Row 3 wraps back to row 0 rather than scrolling.
  function automatic logic [1:0] next_row(input logic [1:0] row);
    return (row == ROW_LAST) ? 2'd0 : (row + 2'd1);
  endfunction

endpackage

// File: rtl/lcd_text_ram.sv
// 80x8 screen image: one synchronous write port, one registered read port.
module lcd_text_ram
  import lcd_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [MEM_BITS-1:0] wr_addr_i,
  input  logic [7:0]          wr_data_i,
  input  logic [MEM_BITS-1:0] rd_addr_i,
  output logic [7:0]          rd_data_o
);

  logic [7:0] mem_q [MAX_MEM];
  logic [7:0] rd_data_q;

  // Storage array; contents deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register: old data on a same-address write, blank beyond the screen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= 8'h00;
    end else if (rd_addr_i <= ADDR_LAST) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= CHR_SPACE;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lcd_text_buffer.sv
// Character frame store feeding the HD44780 driver: byte stream in, screen image out,
// coalesced refresh triggers issued once the stream goes quiet and the driver is idle.
module lcd_text_buffer
  import lcd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic [MEM_BITS-1:0] rd_addr,
  output logic [7:0]          rd_data,
  input  logic                lcd_busy,
  output logic                lcd_trg,
  output logic [1:0]          cur_row,
  output logic [4:0]          cur_col,
  output logic                dirty
);

  main_state_e          main_q, main_d;
  ref_state_e           ref_q, ref_d;
  logic [MEM_BITS-1:0]  clr_addr_q, clr_addr_d;
  logic [1:0]           row_q, row_d;
  logic [4:0]           col_q, col_d;
  logic                 in_ready_q, in_ready_d;
  logic                 dirty_q, dirty_d;
  logic                 trg_q, trg_d;
  logic [HOLD_BITS-1:0] hold_q, hold_d;
  logic [WAIT_BITS-1:0] wait_q, wait_d;

  logic                 accept_s;
  logic                 printable_s;
  logic                 set_dirty_s;
  logic                 wr_en_s;
  logic [MEM_BITS-1:0]  wr_addr_s;
  logic [7:0]           wr_data_s;

  assign accept_s    = in_valid & in_ready_q;
  assign printable_s = (in_data >= CHR_SPACE) && (in_data <= CHR_TILDE);

  // Main FSM: screen clear sweep, byte interpretation and cursor movement.
  always_comb begin
    main_d      = main_q;
    clr_addr_d  = clr_addr_q;
    row_d       = row_q;
    col_d       = col_q;
    in_ready_d  = in_ready_q;
    wr_en_s     = 1'b0;
    wr_addr_s   = clr_addr_q;
    wr_data_s   = CHR_SPACE;
    set_dirty_s = 1'b0;
    case (main_q)
      MS_CLEAR: begin
        wr_en_s = 1'b1;
        row_d   = 2'd0;
        col_d   = 5'd0;
        if (clr_addr_q == ADDR_LAST) begin
          main_d      = MS_IDLE;
          in_ready_d  = 1'b1;
          clr_addr_d  = {MEM_BITS{1'b0}};
          set_dirty_s = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_ONE;
        end
      end
      MS_IDLE: begin
        if (accept_s && printable_s) begin
          wr_en_s     = 1'b1;
          wr_addr_s   = cell_addr(row_q, col_q);
          wr_data_s   = in_data;
          set_dirty_s = 1'b1;
          if (col_q == COL_LAST) begin
            col_d = 5'd0;
            row_d = next_row(row_q);
          end else begin
            col_d = col_q + 5'd1;
          end
        end else if (accept_s) begin
          case (in_data)
            CHR_LF: begin
              col_d = 5'd0;
              row_d = next_row(row_q);
            end
            CHR_CR: col_d = 5'd0;
            CHR_BS: begin
              if (col_q != 5'd0) begin
                col_d = col_q - 5'd1;
              end else begin
                col_d = col_q;
              end
            end
            CHR_FF: begin
              main_d     = MS_CLEAR;
              in_ready_d = 1'b0;
              clr_addr_d = {MEM_BITS{1'b0}};
              row_d      = 2'd0;
              col_d      = 5'd0;
            end
            default: main_d = MS_IDLE;
          endcase
        end else begin
          main_d = MS_IDLE;
        end
      end
      default: begin
        main_d     = MS_CLEAR;
        in_ready_d = 1'b0;
        clr_addr_d = {MEM_BITS{1'b0}};
      end
    endcase
  end

  // Refresh FSM: hold-off after the last byte, one-cycle trigger, then track the print.
  always_comb begin
    ref_d   = ref_q;
    hold_d  = hold_q;
    wait_d  = wait_q;
    dirty_d = dirty_q;
    trg_d   = 1'b0;
    case (ref_q)
      R_IDLE: begin
        hold_d = {HOLD_BITS{1'b0}};
        if (dirty_q) begin
          ref_d = R_HOLD;
        end else begin
          ref_d = R_IDLE;
        end
      end
      R_HOLD: begin
        // A clear in progress is not idle time, so it restarts the hold-off too.
        if (accept_s || (main_q == MS_CLEAR)) begin
          hold_d = {HOLD_BITS{1'b0}};
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_ONE;
        end else if (!lcd_busy) begin
          ref_d = R_TRIG;
          trg_d = 1'b1;
        end else begin
          ref_d = R_HOLD;
        end
      end
      R_TRIG: begin
        dirty_d = 1'b0;
        wait_d  = {WAIT_BITS{1'b0}};
        ref_d   = R_WAIT_HI;
      end
      R_WAIT_HI: begin
        if (lcd_busy) begin
          ref_d = R_WAIT_LO;
        end else if (wait_q == WAIT_LAST) begin
          ref_d = R_IDLE;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      R_WAIT_LO: begin
        if (!lcd_busy) begin
          ref_d = R_IDLE;
        end else begin
          ref_d = R_WAIT_LO;
        end
      end
      default: ref_d = R_IDLE;
    endcase
    if (set_dirty_s) begin
      dirty_d = 1'b1;
    end else begin
      dirty_d = dirty_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= MS_CLEAR;
      ref_q      <= R_IDLE;
      clr_addr_q <= {MEM_BITS{1'b0}};
      row_q      <= 2'd0;
      col_q      <= 5'd0;
      in_ready_q <= 1'b0;
      dirty_q    <= 1'b0;
      trg_q      <= 1'b0;
      hold_q     <= {HOLD_BITS{1'b0}};
      wait_q     <= {WAIT_BITS{1'b0}};
    end else begin
      main_q     <= main_d;
      ref_q      <= ref_d;
      clr_addr_q <= clr_addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      in_ready_q <= in_ready_d;
      dirty_q    <= dirty_d;
      trg_q      <= trg_d;
      hold_q     <= hold_d;
      wait_q     <= wait_d;
    end
  end

  lcd_text_ram u_ram (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_addr_s),
    .wr_data_i (wr_data_s),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign in_ready = in_ready_q;
  assign lcd_trg  = trg_q;
  assign cur_row  = row_q;
  assign cur_col  = col_q;
  assign dirty    = dirty_q;

endmodule
